// File: rtl/ifetch_mem_responder.sv
// Instruction-memory responder: one fetch at a time, word array lookup, registered reply.
// Latency: LATENCY edges from request accept to first rsp_valid cycle (1..15).
// Backpressure: response held stable in RESP until rsp_ready; req_ready low outside IDLE.
module ifetch_mem_responder #(
  parameter int          DEPTH          = 1024,
  parameter logic [31:0] BASE           = 32'h8000_0000,
  parameter int          LATENCY        = 2,
  // Reset value of rsp_count; nonzero only to reach the wrap point quickly in test.
  parameter logic [31:0] RSP_COUNT_INIT = 32'h0000_0000,
  localparam int         IDX_W          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_inst,
  output logic             rsp_err,
  input  logic             ld_wen,
  input  logic [IDX_W-1:0] ld_addr,
  input  logic [31:0]      ld_data,
  output logic [31:0]      rsp_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  // WAIT counts down from here; for LATENCY==1 WAIT is skipped and this is unused.
  localparam logic [3:0]  CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic [3:0]       cnt_nxt;
  logic             accept;
  logic             rsp_hs;
  logic [31:0]      off_word;
  logic [IDX_W-1:0] rd_idx;
  logic             addr_err;
  logic [31:0]      mem [DEPTH];

  // Handshake qualifiers shared by the FSM and the datapath.
  always_comb begin
    accept = req_valid && req_ready;
    rsp_hs = rsp_valid && rsp_ready;
  end

  // Address decode: unsigned offset from BASE, so addresses below BASE wrap high and fail the range test.
  always_comb begin
    off_word = (req_addr - BASE) >> 2;
    rd_idx   = off_word[IDX_W-1:0];
    addr_err = (req_addr[1:0] != 2'b00) || (off_word >= DEPTH_W);
  end

  // State register and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE, one request in flight.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; req_ready is also masked by rst so nothing is accepted during reset.
  always_comb begin
    req_ready = (state == S_IDLE) && !rst;
    rsp_valid = (state == S_RESP);
  end

  // Response capture on the accept edge; the array read sees the contents before any same-edge load.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_inst <= 32'd0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      rsp_err  <= addr_err;
      rsp_inst <= addr_err ? 32'd0 : mem[rd_idx];
    end
  end

  // Completed-response counter, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_count <= RSP_COUNT_INIT;
    end else if (rsp_hs) begin
      rsp_count <= rsp_count + 32'd1;
    end
  end

  // Load port: writes land in every state, reset included; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (ld_wen) begin
      mem[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_ifetch_mem_responder.sv
module tb_ifetch_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rsp_ready;
  logic        ld_wen;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] req_addr;
  logic        v1, v2, v15;
  logic        rq1, rq2, rq15;
  logic        rv1, rv2, rv15;
  logic [31:0] ri1, ri2, ri15;
  logic        re1, re2, re15;
  logic [31:0] rc1, rc2, rc15;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ifetch_mem_responder #(.LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rq2), .req_addr(req_addr),
    .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_inst(ri2), .rsp_err(re2),
    .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data), .rsp_count(rc2)
  );

  ifetch_mem_responder #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rq1), .req_addr(req_addr),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_inst(ri1), .rsp_err(re1),
    .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data), .rsp_count(rc1)
  );

  ifetch_mem_responder #(.LATENCY(15), .RSP_COUNT_INIT(32'hFFFF_FFFF)) u15 (
    .clk(clk), .rst(rst), .req_valid(v15), .req_ready(rq15), .req_addr(req_addr),
    .rsp_valid(rv15), .rsp_ready(rsp_ready), .rsp_inst(ri15), .rsp_err(re15),
    .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data), .rsp_count(rc15)
  );

  function automatic logic get_rv(input int w);
    case (w)
      1:       return rv1;
      15:      return rv15;
      default: return rv2;
    endcase
  endfunction

  function automatic logic [31:0] get_ri(input int w);
    case (w)
      1:       return ri1;
      15:      return ri15;
      default: return ri2;
    endcase
  endfunction

  function automatic logic get_re(input int w);
    case (w)
      1:       return re1;
      15:      return re15;
      default: return re2;
    endcase
  endfunction

  task automatic set_valid(input int w, input logic val);
    case (w)
      1:       v1  = val;
      15:      v15 = val;
      default: v2  = val;
    endcase
  endtask

  // Drive one request (optionally with a load write on the same edge), then wait for rsp_valid.
  // Returns at the negedge of the first rsp_valid cycle with the edges elapsed since accept.
  task automatic issue(input int w, input logic [31:0] a, input logic le, input logic [9:0] la,
                       input logic [31:0] ld, output int lat, output logic [31:0] inst,
                       output logic err);
    @(negedge clk);
    req_addr = a;
    set_valid(w, 1'b1);
    ld_wen  = le;
    ld_addr = la;
    ld_data = ld;
    @(negedge clk);
    set_valid(w, 1'b0);
    ld_wen = 1'b0;
    lat = 1;
    while (!get_rv(w) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    inst = get_ri(w);
    err  = get_re(w);
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b0; ld_wen = 1'b0; ld_addr = '0; ld_data = '0;
    req_addr = '0; v1 = 1'b0; v2 = 1'b0; v15 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (rq2 !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: observed %b, required 0", rq2); end
    n_checks++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: observed %b, required 0", rv2); end
    n_checks++; if (ri2 !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_inst: observed %h, required 0", ri2); end
    n_checks++; if (re2 !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: observed %b, required 0", re2); end
    n_checks++; if (rc2 !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_count: observed %h, required 0", rc2); end
    n_checks++; if (rc15 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_count_preload: observed %h, required ffffffff", rc15); end
    // Fill the array while reset is still asserted.
    ld_wen = 1'b1; ld_addr = 10'd0; ld_data = 32'h0000_0413;
    @(negedge clk);
    ld_addr = 10'd1; ld_data = 32'h0010_0073;
    @(negedge clk);
    ld_addr = 10'd2; ld_data = 32'h0000_0001;
    @(negedge clk);
    ld_wen = 1'b0;
    n_checks++; if (rq2 !== 1'b0) begin n_fail++; $display("FAIL reset_hold_req_ready: observed %b, required 0", rq2); end
    rst = 1'b0;
    #1;
    n_checks++; if (rq2 !== 1'b1) begin n_fail++; $display("FAIL post_reset_req_ready: observed %b, required 1", rq2); end
  endtask

  task automatic test_basic_fetch();
    int lat; logic [31:0] inst; logic err;
    rsp_ready = 1'b1;
    issue(2, 32'h8000_0000, 1'b0, 10'd0, 32'd0, lat, inst, err);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL basic0_latency: observed %0d, required 2", lat); end
    n_checks++; if (inst !== 32'h0000_0413) begin n_fail++; $display("FAIL basic0_inst: observed %h, required 00000413", inst); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic0_err: observed %b, required 0", err); end
    // Back-to-back: next request goes out at the minimum spacing.
    issue(2, 32'h8000_0004, 1'b0, 10'd0, 32'd0, lat, inst, err);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL basic1_latency: observed %0d, required 2", lat); end
    n_checks++; if (inst !== 32'h0010_0073) begin n_fail++; $display("FAIL basic1_inst: observed %h, required 00100073", inst); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic1_err: observed %b, required 0", err); end
    @(negedge clk);
    n_checks++; if (rc2 !== 32'd2) begin n_fail++; $display("FAIL basic_count: observed %0d, required 2", rc2); end
    n_checks++; if (rq2 !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after: observed %b, required 1", rq2); end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] inst; logic err;
    rsp_ready = 1'b0;
    issue(2, 32'h8000_0004, 1'b0, 10'd0, 32'd0, lat, inst, err);
    n_checks++; if (inst !== 32'h0010_0073) begin n_fail++; $display("FAIL bp_inst: observed %h, required 00100073", inst); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (rv2 !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold[%0d]: observed %b, required 1", i, rv2); end
      n_checks++; if (ri2 !== 32'h0010_0073) begin n_fail++; $display("FAIL bp_inst_hold[%0d]: observed %h, required 00100073", i, ri2); end
      n_checks++; if (re2 !== 1'b0) begin n_fail++; $display("FAIL bp_err_hold[%0d]: observed %b, required 0", i, re2); end
      n_checks++; if (rq2 !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready[%0d]: observed %b, required 0", i, rq2); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (rq2 !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: observed %b, required 1", rq2); end
    n_checks++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: observed %b, required 0", rv2); end
    n_checks++; if (rc2 !== 32'd3) begin n_fail++; $display("FAIL bp_count: observed %0d, required 3", rc2); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] inst; logic err;
    logic [31:0] addrs [3];
    addrs[0] = 32'h8000_0002;
    addrs[1] = 32'h7FFF_FFFC;
    addrs[2] = 32'h8000_1000;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(2, addrs[i], 1'b0, 10'd0, 32'd0, lat, inst, err);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_flag[%h]: observed %b, required 1", addrs[i], err); end
      n_checks++; if (inst !== 32'd0) begin n_fail++; $display("FAIL err_inst[%h]: observed %h, required 0", addrs[i], inst); end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL err_latency[%h]: observed %0d, required 2", addrs[i], lat); end
    end
    @(negedge clk);
    n_checks++; if (rc2 !== 32'd6) begin n_fail++; $display("FAIL err_count: observed %0d, required 6", rc2); end
  endtask

  task automatic test_load_collision();
    int lat; logic [31:0] inst; logic err;
    rsp_ready = 1'b1;
    issue(2, 32'h8000_0008, 1'b1, 10'd2, 32'hDEAD_BEEF, lat, inst, err);
    n_checks++; if (inst !== 32'h0000_0001) begin n_fail++; $display("FAIL collide_old: observed %h, required 00000001", inst); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL collide_err: observed %b, required 0", err); end
    issue(2, 32'h8000_0008, 1'b0, 10'd0, 32'd0, lat, inst, err);
    n_checks++; if (inst !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL collide_new: observed %h, required deadbeef", inst); end
    @(negedge clk);
    n_checks++; if (rc2 !== 32'd8) begin n_fail++; $display("FAIL collide_count: observed %0d, required 8", rc2); end
  endtask

  task automatic test_reset_midflight();
    int lat; logic [31:0] inst; logic err;
    logic seen;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_addr = 32'h8000_0000;
    v2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    n_checks++; if (rq2 !== 1'b0) begin n_fail++; $display("FAIL mid_in_wait: observed req_ready %b, required 0", rq2); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (rq2 !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after_rst: observed %b, required 1", rq2); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rv2 === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_valid: observed %b, required 0", seen); end
    n_checks++; if (rc2 !== 32'd0) begin n_fail++; $display("FAIL mid_count: observed %0d, required 0", rc2); end
    issue(2, 32'h8000_0000, 1'b0, 10'd0, 32'd0, lat, inst, err);
    n_checks++; if (inst !== 32'h0000_0413) begin n_fail++; $display("FAIL mid_refetch: observed %h, required 00000413", inst); end
    @(negedge clk);
    n_checks++; if (rc2 !== 32'd1) begin n_fail++; $display("FAIL mid_refetch_count: observed %0d, required 1", rc2); end
  endtask

  task automatic test_latency_sweep();
    int lat; logic [31:0] inst; logic err;
    rsp_ready = 1'b1;
    issue(1, 32'h8000_0004, 1'b0, 10'd0, 32'd0, lat, inst, err);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL lat1_latency: observed %0d, required 1", lat); end
    n_checks++; if (inst !== 32'h0010_0073) begin n_fail++; $display("FAIL lat1_inst: observed %h, required 00100073", inst); end
    @(negedge clk);
    n_checks++; if (rc1 !== 32'd1) begin n_fail++; $display("FAIL lat1_count: observed %0d, required 1", rc1); end
    issue(15, 32'h8000_0000, 1'b0, 10'd0, 32'd0, lat, inst, err);
    n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL lat15_latency: observed %0d, required 15", lat); end
    n_checks++; if (inst !== 32'h0000_0413) begin n_fail++; $display("FAIL lat15_inst: observed %h, required 00000413", inst); end
    n_checks++; if (rc15 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL lat15_count_before: observed %h, required ffffffff", rc15); end
    @(negedge clk);
    n_checks++; if (rc15 !== 32'd0) begin n_fail++; $display("FAIL lat15_count_wrap: observed %h, required 0", rc15); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_errors();
    test_load_collision();
    test_reset_midflight();
    test_latency_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_mem_responder.md
# ifetch_mem_responder

Instruction-memory responder: the memory end of the fetch interface. It accepts one word-aligned fetch address per valid/ready handshake, looks it up in an internal word array, and returns the instruction after a fixed, parameterised latency on a back-pressurable response channel. It sits between the fetch unit's PC output and the decode stage. A side load port fills the array before or during simulation.

## Interface
- `DEPTH`, 1024: number of 32-bit words in the array; must be a power of two; `IDX_W = clog2(DEPTH)`.
- `BASE`, 32'h8000_0000: byte address mapped to word index 0.
- `LATENCY`, 2: cycles from the request accept edge to the first cycle with `rsp_valid` high; legal range 1..15.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: fetch request present.
- `req_ready`  out  1: responder can accept a request this cycle.
- `req_addr`  in  32: byte address of the instruction.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_inst`  out  32: instruction word; 0 when `rsp_err` is set.
- `rsp_err`  out  1: request was misaligned or out of range.
- `ld_wen`  in  1: load-port write enable.
- `ld_addr`  in  IDX_W: load-port word index.
- `ld_data`  in  32: load-port write data.
- `rsp_count`  out  32: number of completed response handshakes; wraps modulo 2^32.

## Operation
- The block has three states:
  - IDLE: `req_ready = !rst`. When `req_valid` is high, the request is accepted, the response is captured, and the block moves to RESP if `LATENCY==1`. Otherwise it moves to WAIT with `cnt = LATENCY-2`.
  - WAIT: when `cnt==0` the block moves to RESP; otherwise `cnt` decrements. `req_ready=0`.
  - RESP: `rsp_valid=1`, `req_ready=0`. When `rsp_ready` is high the block returns to IDLE and `rsp_count` increments.
- `cnt` is a 4-bit register.
- Response capture on the accept edge:
  - `off = req_addr - BASE`, 32-bit unsigned, so addresses below `BASE` wrap to large values.
  - `err = (req_addr[1:0] != 0) || (off[31:2] >= DEPTH)`.
  - `rsp_err <= err`; `rsp_inst <= err ? 0 : mem[off[IDX_W+1:2]]`.
- The array is read on the accept edge. A load write to the same word on that same edge is not visible to that request, which returns the old data. Later writes do not alter an in-flight response.
- `rsp_inst` and `rsp_err` are registered and stay stable from the first `rsp_valid` cycle until the handshake completes.
- Load port: when `ld_wen` is high, `mem[ld_addr] <= ld_data` on the edge. Writes are accepted in every state, including during `rst`.
- Only one request is outstanding at a time. There is no pipelining.

## Timing
- Reset: state is IDLE, `cnt=0`, `rsp_valid=0`, `rsp_inst=0`, `rsp_err=0`, `rsp_count=0`. `req_ready` is 0 while `rst` is high and 1 in the first cycle after it falls. Array contents are not reset.
- Reset mid-operation (in WAIT or RESP) discards the in-flight response with no handshake and no count increment.
- Latency: accept on edge E means `rsp_valid` is first high in cycle E+LATENCY, i.e. after LATENCY rising edges.
- After a response handshake on edge H, `req_ready` is high in the cycle following H. The earliest next accept is edge H+1.
- Minimum request-to-request spacing is `LATENCY+1` edges, reached when `rsp_ready` is held high.
- `req_valid` is ignored outside IDLE. The requester must hold `req_addr` until accepted.
- `rsp_ready` is ignored outside RESP.
- `rsp_count` changes only on RESP handshake edges; `0xFFFF_FFFF + 1` gives 0.

## Test plan
- **Basic fetch:** load `mem[0]=0x00000413` and `mem[1]=0x00100073`. With `LATENCY=2`, request 0x8000_0000 then 0x8000_0004 with `rsp_ready=1`. Required: both words returned, each exactly 2 edges after accept, `rsp_err=0`, `rsp_count=2`.
- **Back-pressure:** hold `rsp_ready=0` for 5 cycles in RESP. Required: `rsp_valid`, `rsp_inst` and `rsp_err` stay constant and `req_ready=0` throughout. After one cycle with `rsp_ready=1`, `req_ready=1` in the next cycle.
- **Error cases:** request 0x8000_0002 (misaligned), 0x7FFF_FFFC (below BASE) and `BASE+4*DEPTH` (past the end). Required for each: `rsp_err=1` and `rsp_inst=0`.
- **Load collision:** on the accept edge of 0x8000_0008, write `mem[2]=0xDEADBEEF` over old value 0x1. Required: the response is 0x1, and a repeat request returns 0xDEADBEEF.
- **Reset mid-flight:** assert `rst` for one cycle while in WAIT. Required: `rsp_valid` never rises for that request and `rsp_count` is unchanged at 0. `req_ready=1` in the cycle after `rst` falls.
- **Latency sweep:** `LATENCY` of 1 and 15, and `rsp_count` wrap from `0xFFFF_FFFF` forced via a preload test hook or a long run. Required: first `rsp_valid` at accept+1 and accept+15 respectively, and the count returns to 0.
